// File: rtl/prim_generic_pipe.sv
// prim_generic_pipe: Depth-stage valid/ready register pipeline with flush and occupancy count.
// Optional per-stage even parity with err_o check when PRIM_GENERIC_PIPE_PARITY_EN is defined.
module prim_generic_pipe #(
  parameter int unsigned      Width      = 1,
  parameter int unsigned      Depth      = 2,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [Width-1:0]             in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [Width-1:0]             out_data_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         err_o
);
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [Depth-1:0]             r_vld;
  logic [Depth-1:0][Width-1:0]  r_dat;
  logic [CntW-1:0]              r_cnt;
  logic [Depth-1:0]             w_ld;
  logic [Depth-1:0]             w_src_vld;
  logic [Depth-1:0][Width-1:0]  w_src_dat;
  logic                         w_in_xfer;
  logic                         w_out_xfer;

  // Stage k can load when the output drains or any stage from k to the output has a hole.
  for (genvar k = 0; k < Depth; k++) begin : g_ld
    assign w_ld[k] = out_ready_i | ~(&r_vld[Depth-1:k]);
  end

  assign in_ready_o  = w_ld[0] & ~flush_i;
  assign w_in_xfer   = in_valid_i & in_ready_o;
  assign w_out_xfer  = r_vld[Depth-1] & out_ready_i;
  assign out_valid_o = r_vld[Depth-1];
  assign out_data_o  = r_dat[Depth-1];
  assign count_o     = r_cnt;

  always_comb begin
    w_src_vld    = '0;
    w_src_dat    = '0;
    w_src_vld[0] = w_in_xfer;
    w_src_dat[0] = in_data_i;
    for (int k = 1; k < Depth; k++) begin
      w_src_vld[k] = r_vld[k-1];
      w_src_dat[k] = r_dat[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_vld <= '0;
      r_dat <= {Depth{ResetValue}};
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < Depth; k++) begin
        if (w_ld[k]) begin
          r_vld[k] <= w_src_vld[k];
          if (w_src_vld[k]) r_dat[k] <= w_src_dat[k];
        end
      end
      if (w_in_xfer && !w_out_xfer)      r_cnt <= r_cnt + CntW'(1);
      else if (!w_in_xfer && w_out_xfer) r_cnt <= r_cnt - CntW'(1);
    end
  end

`ifdef PRIM_GENERIC_PIPE_PARITY_EN
  logic [Depth-1:0] r_par;
  logic [Depth-1:0] w_src_par;

  always_comb begin
    w_src_par    = '0;
    w_src_par[0] = ^in_data_i;
    for (int k = 1; k < Depth; k++) w_src_par[k] = r_par[k-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_par <= {Depth{^ResetValue}};
    end else begin
      for (int k = 0; k < Depth; k++) begin
        if (w_ld[k] && w_src_vld[k]) r_par[k] <= w_src_par[k];
      end
    end
  end

  assign err_o = r_vld[Depth-1] & ((^r_dat[Depth-1]) != r_par[Depth-1]);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_generic_pipe.sv
// Randomized + directed bench for prim_generic_pipe (Width=8, Depth=3) against a slot-queue model.
module tb_prim_generic_pipe;
  localparam int W = 8;
  localparam int D = 3;
  localparam logic [W-1:0] RV = 8'h5A;

  logic         clk = 1'b0;
  logic         rst_i, flush_i, in_valid_i, out_ready_i;
  logic [W-1:0] in_data_i;
  logic         in_ready_o, out_valid_o, err_o;
  logic [W-1:0] out_data_o;
  logic [1:0]   count_o;

  prim_generic_pipe #(.Width(W), .Depth(D), .ResetValue(RV)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: D slots, index D-1 is the output; words advance one slot per cycle into holes.
  bit           m_v [D];
  logic [W-1:0] m_d [D];
  logic [W-1:0] exp_q [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < D; k++) begin m_v[k] = 0; m_d[k] = RV; end
    exp_q.delete();
  endtask

  function automatic int model_occ();
    int n = 0;
    for (int k = 0; k < D; k++) n += int'(m_v[k]);
    return n;
  endfunction

  function automatic logic model_rdy();
    bit cv [D];
    cv = m_v;
    if (cv[D-1] && out_ready_i) cv[D-1] = 0;
    for (int k = D-2; k >= 0; k--)
      if (cv[k] && !cv[k+1]) begin cv[k+1] = 1; cv[k] = 0; end
    return !cv[0] && !flush_i;
  endfunction

  task automatic model_step(input logic ixfer);
    if (rst_i || flush_i) begin
      for (int k = 0; k < D; k++) begin m_v[k] = 0; m_d[k] = RV; end
    end else begin
      if (m_v[D-1] && out_ready_i) m_v[D-1] = 0;
      for (int k = D-2; k >= 0; k--)
        if (m_v[k] && !m_v[k+1]) begin
          m_v[k+1] = 1; m_d[k+1] = m_d[k]; m_v[k] = 0;
        end
      if (ixfer) begin m_v[0] = 1; m_d[0] = in_data_i; end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic cycle();
    logic exp_rdy, ixfer;
    #1;
    exp_rdy = model_rdy();
    chk("in_ready", in_ready_o, exp_rdy);
    chk("out_valid", out_valid_o, m_v[D-1]);
    if (m_v[D-1]) chk("out_data", out_data_o, m_d[D-1]);
    chk("count", count_o, model_occ());
    chk("err", err_o, 0);
    if (out_valid_o && out_ready_i && !rst_i) begin
      if (exp_q.size() == 0) chk("sb_spurious_out", 1, 0);
      else chk("sb_order", out_data_o, exp_q.pop_front());
    end
    ixfer = in_valid_i && exp_rdy && !rst_i;
    @(posedge clk);
    model_step(ixfer);
    if (rst_i || flush_i) exp_q.delete();
    if (ixfer) exp_q.push_back(in_data_i);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy);
    in_valid_i = v; in_data_i = d; out_ready_i = ordy;
  endtask

  initial begin
    rst_i = 1; flush_i = 0;
    drive(0, 8'h00, 0);
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_i = 0;
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 8'h5A);
    chk("rst_count", count_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_in_ready", in_ready_o, 1);

    // Back-to-back 0x11,0x22,0x33 with output always ready.
    drive(1, 8'h11, 1); cycle();
    drive(1, 8'h22, 1); cycle();
    drive(1, 8'h33, 1); cycle();
    drive(0, 8'h00, 1);
    chk("b2b_c3_valid", out_valid_o, 1);
    chk("b2b_c3_data", out_data_o, 8'h11);
    chk("b2b_c3_count", count_o, 3);
    cycle();
    chk("b2b_c4_data", out_data_o, 8'h22);
    chk("b2b_c4_count", count_o, 2);
    cycle();
    chk("b2b_c5_data", out_data_o, 8'h33);
    cycle();
    chk("b2b_drained", out_valid_o, 0);

    // Fill under stall, then release with a 4th word pending.
    drive(1, 8'hA1, 0); cycle();
    drive(1, 8'hA2, 0); cycle();
    drive(1, 8'hA3, 0); cycle();
    drive(1, 8'hA4, 0);
    #1;
    chk("full_count", count_o, 3);
    chk("full_in_ready", in_ready_o, 0);
    chk("full_head", out_data_o, 8'hA1);
    cycle();
    out_ready_i = 1;
    #1;
    chk("release_in_ready", in_ready_o, 1);
    cycle();
    chk("release_count", count_o, 3);
    chk("release_head", out_data_o, 8'hA2);
    drive(0, 8'h00, 1);
    repeat (3) cycle();

    // Flush with two words held and an input offered.
    drive(1, 8'hB1, 0); cycle();
    drive(1, 8'hB2, 0); cycle();
    chk("pre_flush_count", count_o, 2);
    drive(1, 8'hB3, 0); flush_i = 1;
    #1;
    chk("flush_in_ready", in_ready_o, 0);
    cycle();
    flush_i = 0;
    chk("flush_count", count_o, 0);
    chk("flush_out_valid", out_valid_o, 0);
    chk("flush_out_data", out_data_o, 8'h5A);

    // Reset while full and draining.
    drive(1, 8'hC1, 0); cycle();
    drive(1, 8'hC2, 0); cycle();
    drive(1, 8'hC3, 0); cycle();
    drive(0, 8'h00, 1); rst_i = 1;
    cycle();
    rst_i = 0;
    chk("midrst_out_valid", out_valid_o, 0);
    chk("midrst_count", count_o, 0);
    cycle();
    chk("midrst_still_empty", out_valid_o, 0);

`ifdef PRIM_GENERIC_PIPE_PARITY_EN
    begin
      logic b;
      drive(1, 8'h3C, 0); cycle();
      drive(0, 8'h00, 0); cycle(); cycle();
      b = out_data_o[0];
      force dut.r_dat[D-1][0] = ~b;
      #1;
      chk("parity_err", err_o, 1);
      release dut.r_dat[D-1][0];
      flush_i = 1;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      flush_i = 0;
    end
`endif

    for (int i = 0; i < 2000; i++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      in_data_i   = W'($urandom);
      out_ready_i = ($urandom_range(0, 9) < 7);
      flush_i     = ($urandom_range(0, 49) == 0);
      rst_i       = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prim_generic_pipe.md
PRIM_GENERIC_PIPE -- requirements
Module: prim_generic_pipe

Interface
REQ-001 The block SHALL have parameter Width, default 1, meaning the data width in bits; legal values are 1 or greater.
REQ-002 The block SHALL have parameter Depth, default 2, meaning the number of register stages; legal values are 1 or greater.
REQ-003 The block SHALL have parameter ResetValue [Width-1:0], default 0, meaning the data value loaded into every stage on reset or flush.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port flush_i, input, 1 bit: synchronous clear of all stage contents.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit: upstream data valid.
REQ-008 The block SHALL have port in_ready_o, output, 1 bit: block accepts in_data_i this cycle.
REQ-009 The block SHALL have port in_data_i, input, Width bits: upstream data.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit: the last stage holds valid data.
REQ-011 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts data.
REQ-012 The block SHALL have port out_data_o, output, Width bits: the last-stage data.
REQ-013 The block SHALL have port count_o, output, $clog2(Depth+1) bits: the number of valid stages.
REQ-014 The block SHALL have port err_o, output, 1 bit: parity error on the output stage.

Function
REQ-015 Each stage SHALL hold one valid bit and one Width-bit data word; stage 0 is the input stage and stage Depth-1 drives out_* directly from registers.
REQ-016 A transfer SHALL occur on an interface only when valid and ready are both high in the same cycle.
REQ-017 Stage k SHALL be able to load when it is empty or its content leaves in the same cycle; the last stage leaves on out_valid_o && out_ready_i.
REQ-018 in_ready_o SHALL equal the stage-0 load condition combined with !flush_i; ready may depend combinationally on out_ready_i.
REQ-019 A data word on an unstalled, empty pipe SHALL appear on out_data_o exactly Depth cycles after its input transfer.
REQ-020 With out_ready_i held high, the block SHALL sustain one transfer per cycle, with no bubbles inserted.
REQ-021 When out_ready_i is low, stages SHALL fill from the output backward; the block SHALL be full when count_o = Depth, and then in_ready_o SHALL be 0.
REQ-022 A simultaneous input transfer and output transfer when full SHALL leave count_o unchanged.
REQ-023 Data in a stalled stage SHALL remain stable, and out_valid_o SHALL NOT drop without an output transfer, a flush or a reset.
REQ-024 count_o SHALL increment by 1 per input-only transfer and decrement by 1 per output-only transfer, registered, and SHALL never wrap.
REQ-025 On flush_i high, the next cycle SHALL show every valid bit = 0, data = ResetValue and count_o = 0; no input SHALL be accepted in the flush cycle.
REQ-026 An output transfer in the flush cycle SHALL be a legitimate transfer.

Reset
REQ-027 On rst_i high at a clock edge, all valid bits SHALL clear, all data SHALL load ResetValue, and count_o SHALL become 0.
REQ-028 After reset, the outputs SHALL be out_valid_o=0, out_data_o=ResetValue, count_o=0, err_o=0, and in_ready_o=1 (when flush_i=0).
REQ-029 Reset SHALL take priority over flush and any transfer.
REQ-030 Reset mid-operation SHALL discard all in-flight words without producing any output transfer.

Configuration
REQ-031 With macro PRIM_GENERIC_PIPE_PARITY_EN defined, each stage SHALL store one extra even-parity bit computed from in_data_i at input.
REQ-032 With PRIM_GENERIC_PIPE_PARITY_EN defined, err_o SHALL = out_valid_o && (^out_data_o != stored parity), combinationally.
REQ-033 With PRIM_GENERIC_PIPE_PARITY_EN defined, the parity bit SHALL reset and flush to ^ResetValue.
REQ-034 Without PRIM_GENERIC_PIPE_PARITY_EN, no parity storage SHALL exist and err_o SHALL be tied to 0.

Verification
REQ-035 Width=8, Depth=3: send 0x11,0x22,0x33 back-to-back with out_ready_i=1 -> outputs appear in order at cycles 3,4,5 after the first input; count_o peaks at 3.
REQ-036 Depth=3, out_ready_i=0: offer 4 words -> 3 accepted, in_ready_o=0, count_o=3; raise out_ready_i -> 4th accepted in the same cycle as the first output.
REQ-037 Pipe holding 2 words: pulse flush_i with in_valid_i=1 -> in_ready_o=0 that cycle; next cycle count_o=0, out_valid_o=0, out_data_o=ResetValue.
REQ-038 rst_i asserted with the pipe full and out_ready_i=1 -> next cycle all valid bits clear, no further output valid, and count_o=0.
REQ-039 PRIM_GENERIC_PIPE_PARITY_EN defined: bench forces one data bit flip in the last stage -> err_o=1 while out_valid_o=1; without the macro, err_o stays 0.
